// File: rtl/ita_marquee14.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ita_marquee14 : multiplexed 14-segment marquee, writable text buffer + scroll
// Rev 1.0
// ---------------------------------------------------------------------------
module ita_marquee14 #(
   parameter int DIGITS        = 12,
   parameter int BUF_LEN       = 16,
   parameter int DWELL         = 4,
   parameter int SCROLL_FRAMES = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       enable_i,
   input  logic                       scroll_en_i,
   input  logic                       offset_clr_i,
   input  logic                       wr_en_i,
   input  logic [$clog2(BUF_LEN)-1:0] wr_addr_i,
   input  logic [5:0]                 wr_data_i,
   output logic [DIGITS-1:0]          sel_o,
   output logic [13:0]                segm_o,
   output logic                       frame_done_o
);

   localparam int AW  = $clog2(BUF_LEN);
   localparam int DGW = $clog2(DIGITS);
   localparam int DCW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam int FCW = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;

   localparam logic [DCW-1:0] DC_LAST  = DCW'(DWELL - 1);
   localparam logic [DGW-1:0] DIG_LAST = DGW'(DIGITS - 1);
   localparam logic [FCW-1:0] FC_LAST  = FCW'(SCROLL_FRAMES - 1);

   // Segment order, MSB first: a b c d e f g1 g2 h i j k l m
   function automatic logic [13:0] glyph(input logic [5:0] c);
      case (c)
         6'd0:  glyph = 14'b11111100001001;
         6'd1:  glyph = 14'b01100000000000;
         6'd2:  glyph = 14'b11011011000000;
         6'd3:  glyph = 14'b11110001000000;
         6'd4:  glyph = 14'b01100111000000;
         6'd5:  glyph = 14'b10110111000000;
         6'd6:  glyph = 14'b10111111000000;
         6'd7:  glyph = 14'b11100000000000;
         6'd8:  glyph = 14'b11111111000000;
         6'd9:  glyph = 14'b11110111000000;
         6'd10: glyph = 14'b11101111000000;
         6'd11: glyph = 14'b11110001010010;
         6'd12: glyph = 14'b10011100000000;
         6'd13: glyph = 14'b11110000010010;
         6'd14: glyph = 14'b10011110000000;
         6'd15: glyph = 14'b10001110000000;
         6'd16: glyph = 14'b10111101000000;
         6'd17: glyph = 14'b01101111000000;
         6'd18: glyph = 14'b10010000010010;
         6'd19: glyph = 14'b01111000000000;
         6'd20: glyph = 14'b00001110001100;
         6'd21: glyph = 14'b00011100000000;
         6'd22: glyph = 14'b01101100101000;
         6'd23: glyph = 14'b01101100100100;
         6'd24: glyph = 14'b11111100000000;
         6'd25: glyph = 14'b11001111000000;
         6'd26: glyph = 14'b11111100000100;
         6'd27: glyph = 14'b11001111000100;
         6'd28: glyph = 14'b10110111000000;
         6'd29: glyph = 14'b10000000010010;
         6'd30: glyph = 14'b01111100000000;
         6'd31: glyph = 14'b00001100001001;
         6'd32: glyph = 14'b01101100000101;
         6'd33: glyph = 14'b00000000101101;
         6'd34: glyph = 14'b00000000101010;
         6'd35: glyph = 14'b10010000001001;
         default: glyph = 14'b0;
      endcase
   endfunction

   logic [5:0]        mem_q [BUF_LEN];
   logic [DCW-1:0]    dc_q, dc_d;
   logic [DGW-1:0]    dig_q, dig_d;
   logic [FCW-1:0]    fc_q, fc_d;
   logic [AW-1:0]     off_q, off_d;
   logic [DIGITS-1:0] sel_q, sel_d;
   logic [13:0]       segm_q, segm_d;
   logic              fd_q, fd_d;
   logic              tick, last_dig;
   logic [AW-1:0]     rd_idx;

   always_comb begin
      tick     = enable_i && (dc_q == DC_LAST);
      last_dig = (dig_q == DIG_LAST);
      // Power-of-two depth: the modulo is just the natural AW-bit wrap.
      rd_idx   = off_q + AW'(dig_q);

      dc_d   = (!enable_i || tick) ? '0 : dc_q + 1'b1;
      dig_d  = dig_q;
      sel_d  = sel_q;
      segm_d = segm_q;
      if (!enable_i) begin
         dig_d  = '0;
         sel_d  = '0;
         segm_d = '0;
      end else if (tick) begin
         dig_d  = last_dig ? '0 : dig_q + 1'b1;
         sel_d  = DIGITS'(1) << dig_q;
         segm_d = glyph(mem_q[rd_idx]);
      end
      fd_d = tick && last_dig;

      fc_d  = fc_q;
      off_d = off_q;
      if (offset_clr_i) begin
         fc_d  = '0;
         off_d = '0;
      end else if (tick && last_dig && scroll_en_i) begin
         if (fc_q == FC_LAST) begin
            fc_d  = '0;
            off_d = off_q + 1'b1;
         end else begin
            fc_d = fc_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         dc_q   <= '0;
         dig_q  <= '0;
         fc_q   <= '0;
         off_q  <= '0;
         sel_q  <= '0;
         segm_q <= '0;
         fd_q   <= 1'b0;
      end else begin
         dc_q   <= dc_d;
         dig_q  <= dig_d;
         fc_q   <= fc_d;
         off_q  <= off_d;
         sel_q  <= sel_d;
         segm_q <= segm_d;
         fd_q   <= fd_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < BUF_LEN; i++) mem_q[i] <= 6'd36;
      end else if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   assign sel_o        = sel_q;
   assign segm_o       = segm_q;
   assign frame_done_o = fd_q;

endmodule
`default_nettype wire

// File: tb/tb_ita_marquee14.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ita_marquee14 : vectors, corner sequences and random traffic vs. a model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ita_marquee14;
   localparam int DIGITS  = 12;
   localparam int BUF_LEN = 16;
   localparam int DWELL   = 4;
   localparam int SF      = 2;

   localparam logic [13:0] G_B = 14'b11110001010010;
   localparam logic [13:0] G_R = 14'b11001111000100;
   localparam logic [13:0] G_L = 14'b00011100000000;
   localparam logic [13:0] G_Z = 14'b10010000001001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable, scroll_en, offset_clr, wr_en;
   logic [3:0]  wr_addr;
   logic [5:0]  wr_data;
   logic [11:0] sel;
   logic [13:0] segm;
   logic        frame_done;

   always #5 clk = ~clk;

   ita_marquee14 #(.DIGITS(DIGITS), .BUF_LEN(BUF_LEN), .DWELL(DWELL), .SCROLL_FRAMES(SF)) dut (
      .clk_i(clk), .rst_ni(rst_n), .enable_i(enable), .scroll_en_i(scroll_en),
      .offset_clr_i(offset_clr), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
      .sel_o(sel), .segm_o(segm), .frame_done_o(frame_done));

   logic [13:0] font [0:35] = '{
      14'b11111100001001, 14'b01100000000000, 14'b11011011000000, 14'b11110001000000,
      14'b01100111000000, 14'b10110111000000, 14'b10111111000000, 14'b11100000000000,
      14'b11111111000000, 14'b11110111000000, 14'b11101111000000, 14'b11110001010010,
      14'b10011100000000, 14'b11110000010010, 14'b10011110000000, 14'b10001110000000,
      14'b10111101000000, 14'b01101111000000, 14'b10010000010010, 14'b01111000000000,
      14'b00001110001100, 14'b00011100000000, 14'b01101100101000, 14'b01101100100100,
      14'b11111100000000, 14'b11001111000000, 14'b11111100000100, 14'b11001111000100,
      14'b10110111000000, 14'b10000000010010, 14'b01111100000000, 14'b00001100001001,
      14'b01101100000101, 14'b00000000101101, 14'b00000000101010, 14'b10010000001001};

   typedef struct {
      logic [5:0]  code;
      logic [13:0] exp_segm;
   } glyph_vec_t;
   glyph_vec_t vecs [8];

   int n_checks = 0;
   int n_errors = 0;

   // Reference: time-based view of the scan (enabled cycles since start).
   int          m_buf [BUF_LEN];
   int          m_cnt, m_off, m_fc;
   logic [11:0] e_sel;
   logic [13:0] e_segm;
   logic        e_fd;

   function automatic logic [13:0] ref_glyph(int c);
      return (c < 36) ? font[c] : 14'd0;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < BUF_LEN; i++) m_buf[i] = 36;
      m_cnt = 0; m_off = 0; m_fc = 0;
      e_sel = '0; e_segm = '0; e_fd = 1'b0;
   endtask

   task automatic model_step();
      int d;
      if (!enable) begin
         m_cnt = 0; e_sel = '0; e_segm = '0; e_fd = 1'b0;
      end else begin
         m_cnt++;
         e_fd = 1'b0;
         if (m_cnt % DWELL == 0) begin
            d      = (m_cnt / DWELL - 1) % DIGITS;
            e_sel  = 12'(1) << d;
            e_segm = ref_glyph(m_buf[(m_off + d) % BUF_LEN]);
            if (d == DIGITS - 1) begin
               e_fd = 1'b1;
               if (scroll_en) begin
                  m_fc++;
                  if (m_fc == SF) begin
                     m_fc  = 0;
                     m_off = (m_off + 1) % BUF_LEN;
                  end
               end
            end
         end
      end
      if (offset_clr) begin
         m_off = 0; m_fc = 0;
      end
      if (wr_en) m_buf[wr_addr] = int'(wr_data);
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("sel", 32'(sel), 32'(e_sel));
      chk("segm", 32'(segm), 32'(e_segm));
      chk("frame_done", 32'(frame_done), 32'(e_fd));
   endtask

   // Wait for a fresh load of the given select pattern.
   task automatic wait_load(logic [11:0] t);
      int n = 0;
      while (sel === t && n < 200) begin cycle(); n++; end
      while (sel !== t && n < 200) begin cycle(); n++; end
      if (sel !== t) chk("wait_load_timeout", 32'(sel), 32'(t));
   endtask

   initial begin
      vecs[0] = '{6'd11, 14'b11110001010010};
      vecs[1] = '{6'd27, 14'b11001111000100};
      vecs[2] = '{6'd18, 14'b10010000010010};
      vecs[3] = '{6'd10, 14'b11101111000000};
      vecs[4] = '{6'd0,  14'b11111100001001};
      vecs[5] = '{6'd8,  14'b11111111000000};
      vecs[6] = '{6'd36, 14'b00000000000000};
      vecs[7] = '{6'd63, 14'b00000000000000};

      enable = 0; scroll_en = 0; offset_clr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
      model_reset();
      #1 rst_n = 1'b0;
      @(posedge clk); #1;
      chk("rst_sel", 32'(sel), 0);
      chk("rst_segm", 32'(segm), 0);
      chk("rst_fd", 32'(frame_done), 0);
      rst_n = 1'b1;
      enable = 1;

      repeat (3) cycle();
      chk("pre_tick_sel", 32'(sel), 0);
      cycle();
      chk("first_sel", 32'(sel), 32'h001);
      wait_load(12'h800);
      chk("fd_last_digit", 32'(frame_done), 1);
      cycle();
      chk("fd_one_cycle", 32'(frame_done), 0);
      wait_load(12'h001);
      chk("sel_wrap", 32'(sel), 32'h001);

      for (int i = 0; i < 8; i++) begin
         wr_en = 1; wr_addr = 0; wr_data = vecs[i].code;
         cycle();
         wr_en = 0;
         wait_load(12'h001);
         chk($sformatf("glyph_code%0d", vecs[i].code), 32'(segm), 32'(vecs[i].exp_segm));
      end

      begin
         int txt [9] = '{11, 27, 18, 21, 21, 10, 23, 29, 14};
         for (int i = 0; i < 9; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_data = 6'(txt[i]);
            cycle();
         end
         wr_en = 0;
      end
      wait_load(12'h001);
      chk("text_d0_B", 32'(segm), 32'(G_B));
      wait_load(12'h200);
      chk("text_d9_blank", 32'(segm), 0);

      offset_clr = 1; scroll_en = 1;
      cycle();
      offset_clr = 0;
      wait_load(12'h001);
      chk("scroll_f1_B", 32'(segm), 32'(G_B));
      wait_load(12'h001);
      chk("scroll_f2_R", 32'(segm), 32'(G_R));
      repeat (29) wait_load(12'h001);
      chk("scroll_off15_blank", 32'(segm), 0);
      wait_load(12'h001);
      chk("scroll_wrap_B", 32'(segm), 32'(G_B));

      wait_load(12'h400);
      wait_load(12'h400);
      repeat (3) cycle();
      offset_clr = 1;
      cycle();
      offset_clr = 0;
      chk("clr_edge_fd", 32'(frame_done), 1);
      wait_load(12'h001);
      chk("clr_wins_B", 32'(segm), 32'(G_B));
      wait_load(12'h001);
      chk("clr_fc0_B", 32'(segm), 32'(G_B));
      wait_load(12'h001);
      chk("clr_then_R", 32'(segm), 32'(G_R));

      wait_load(12'h020);
      cycle();
      enable = 0;
      cycle();
      chk("dis_sel", 32'(sel), 0);
      chk("dis_segm", 32'(segm), 0);
      enable = 1;
      repeat (3) cycle();
      chk("reen_wait", 32'(sel), 0);
      cycle();
      chk("reen_sel", 32'(sel), 32'h001);
      chk("reen_off_kept", 32'(segm), 32'(G_R));

      offset_clr = 1; scroll_en = 0;
      cycle();
      offset_clr = 0;
      wait_load(12'h004);
      repeat (3) cycle();
      wr_en = 1; wr_addr = 4'd3; wr_data = 6'd35;
      cycle();
      wr_en = 0;
      chk("wr_tick_sel", 32'(sel), 32'h008);
      chk("wr_tick_old", 32'(segm), 32'(G_L));
      wait_load(12'h008);
      chk("wr_tick_new", 32'(segm), 32'(G_Z));

      repeat (7) cycle();
      #2 rst_n = 1'b0;
      #1;
      chk("arst_sel", 32'(sel), 0);
      chk("arst_segm", 32'(segm), 0);
      chk("arst_fd", 32'(frame_done), 0);
      model_reset();
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_load(12'h004);
      chk("arst_buf_blank", 32'(segm), 0);

      for (int i = 0; i < 3000; i++) begin
         enable     = ($urandom % 16) != 0;
         scroll_en  = ($urandom % 2) != 0;
         offset_clr = ($urandom % 64) == 0;
         wr_en      = ($urandom % 4) == 0;
         wr_addr    = 4'($urandom % 16);
         wr_data    = 6'($urandom % 64);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ita_marquee14.md
# ita_marquee14

Parametrised 14-segment multiplexed marquee driver: generalises the fixed-text digit scanner to a writable character buffer, configurable digit count, dwell time and optional scrolling. Holds BUF_LEN character codes in an internal register file, refreshes DIGITS common-select lines one at a time, and renders each character through the shared 14-segment glyph set. Sits between the user-project bus/logic (which loads text) and the display pad outputs.

## Interface
- DIGITS, 12, number of select lines / visible positions (2..16)
- BUF_LEN, 16, character buffer depth; must be a power of two and ≥ DIGITS
- DWELL, 4, clock cycles each digit stays selected (≥ 1)
- SCROLL_FRAMES, 8, full refresh frames per one-position scroll step (≥ 1)

- clk  in  1  single system clock, all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- enable  in  1  1 = scan display; 0 = blank and hold position at 0
- scroll_en  in  1  1 = advance scroll offset every SCROLL_FRAMES frames
- offset_clr  in  1  synchronous clear of scroll offset to 0
- wr_en  in  1  buffer write strobe
- wr_addr  in  log2(BUF_LEN)  buffer write address
- wr_data  in  6  character code
- sel  out  DIGITS  one-hot digit select, registered
- segm  out  14  segment pattern, registered, bit 13 = segment a
- frame_done  out  1  one-cycle pulse when last digit of a frame is loaded

## Operation
- Character codes: 0–9 digits, 10–35 letters A–Z, 36–63 blank (segm = 0). Glyphs come from the team's shared 14-segment font include; e.g. B = 14'b11110001010010, R = 14'b11001111000100, I = 14'b10010000010010, A = 14'b11101111000000.
- Buffer write: wr_en=1 stores wr_data at wr_addr on the rising edge; no handshake, always accepted.
- Dwell counter dc counts 0..DWELL-1; tick = enable && dc==DWELL-1.
- On tick: sel <= 1<<dig; segm <= glyph(buf[(offset+dig) mod BUF_LEN]); dig <= (dig==DIGITS-1) ? 0 : dig+1.
- When tick with dig==DIGITS-1: frame_done=1 next cycle for one cycle; frame counter fc increments, wraps at SCROLL_FRAMES-1.
- Scroll: on that same edge, if scroll_en && fc==SCROLL_FRAMES-1, offset <= (offset+1) mod BUF_LEN. New offset applies from the next frame's digit 0; never mid-frame.
- scroll_en=0: offset and fc frozen; scan continues.
- offset_clr=1: offset <= 0 and fc <= 0, takes priority over scroll increment on the same edge.
- enable=0: next edge sel <= 0, segm <= 0, dc <= 0, dig <= 0, frame_done <= 0; offset, fc and buffer retained.

## Timing
- Reset (async, rst_n=0): sel=0, segm=0, frame_done=0, dc=0, dig=0, fc=0, offset=0, all buffer entries = 36 (blank).
- After rst_n rises with enable=1: first tick at edge DWELL; sel=1 from cycle DWELL onward.
- Each digit selected exactly DWELL cycles; frame period = DIGITS·DWELL cycles; scroll step every SCROLL_FRAMES·DIGITS·DWELL cycles.
- Write/read same edge at same address: the read (segm load) uses the old contents; new data visible from the next load of that position.
- Exactly one sel bit high whenever enable=1 and at least one tick has occurred; never two bits high.
- Offset wraps BUF_LEN-1 → 0; fc wraps SCROLL_FRAMES-1 → 0; dig wraps DIGITS-1 → 0.
- rst_n asserted mid-frame: outputs go to reset values immediately (asynchronous), buffer cleared.
- enable re-asserted: scan restarts at digit 0 after DWELL cycles.

## Test plan
- Reset, enable=1, no writes, DIGITS=12, DWELL=4: first sel=12'h001 at cycle 4, segm=0 throughout; sel advances every 4 cycles, wraps 12'h800 → 12'h001; frame_done every 48 cycles.
- Write "BRILLANTE" (11,27,18,21,21,10,23,29,14) at 0..8, scroll_en=0: digits 0..8 show B,R,I,L,L,A,N,T,E glyphs (digit 0 segm=14'b11110001010010), digits 9..11 segm=0.
- Same text, scroll_en=1, SCROLL_FRAMES=2: after 2 frames digit 0 shows R (14'b11001111000100); after 32 frames offset back to 0, digit 0 shows B.
- offset_clr and scroll increment on same edge: offset = 0, fc = 0.
- enable dropped mid-frame at digit 5: next cycle sel=0, segm=0; re-enable → digit 0 selected DWELL cycles later with unchanged offset.
- Write to the position being loaded on the tick edge: segm shows old glyph; new glyph appears one frame later.
